// File: rtl/engine_ctrl_pkg.sv
// Shared types and helpers for the multi-engine kernel control path.
package engine_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } ctrl_state_e;

  function automatic int unsigned WORD_BYTES(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/rr_block_pointer.sv
// Round-robin block pointer: tracks current engine, beat within block and
// beats remaining for one stream side of the multi-engine controller.
module rr_block_pointer
  import engine_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_ENGINES = 4,
  parameter  int unsigned BLOCK_WORDS = 16,
  localparam int unsigned ENG_W       = idx_width(NUM_ENGINES),
  localparam int unsigned CNT_W       = idx_width(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [31:0]      words,
  input  logic             enable,
  input  logic             step,
  output logic [ENG_W-1:0] eng,
  output logic             active_c,
  output logic             last_c
);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      rem;

  assign active_c = enable && (rem != 32'd0);
  assign last_c   = (cnt == CNT_W'(BLOCK_WORDS - 1)) || (rem == 32'd1);

  // A short final block also closes on the last remaining beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng <= '0;
      cnt <= '0;
      rem <= '0;
    end else if (load) begin
      eng <= '0;
      cnt <= '0;
      rem <= words;
    end else if (step && active_c) begin
      rem <= rem - 32'd1;
      if (last_c) begin
        cnt <= '0;
        eng <= (eng == ENG_W'(NUM_ENGINES - 1)) ? '0 : eng + ENG_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_engine_control.sv
// Kernel control path distributing a stream over NUM_ENGINES engines in
// round-robin blocks. Optional counters: MULTI_ENGINE_CONTROL_PERF_EN.
module multi_engine_control
  import engine_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned BLOCK_WORDS = 16,
  parameter int unsigned ADDR_WIDTH  = 64
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              ap_start,
  input  logic                              ap_continue,
  output logic                              ap_idle,
  output logic                              ap_ready,
  output logic                              ap_done,
  input  logic [ADDR_WIDTH-1:0]             src_addr,
  input  logic [ADDR_WIDTH-1:0]             dest_addr,
  input  logic [31:0]                       words_num,
  output logic                              rmst_start,
  output logic [ADDR_WIDTH-1:0]             rmst_addr,
  output logic [ADDR_WIDTH-1:0]             rmst_size,
  input  logic                              rmst_done,
  output logic                              wmst_start,
  output logic [ADDR_WIDTH-1:0]             wmst_addr,
  output logic [ADDR_WIDTH-1:0]             wmst_size,
  input  logic                              wmst_done,
  input  logic                              rmst_tvalid,
  input  logic [DATA_WIDTH-1:0]             rmst_tdata,
  output logic                              rmst_tready,
  output logic [NUM_ENGINES-1:0]            eng_in_tvalid,
  output logic [DATA_WIDTH-1:0]             eng_in_tdata,
  output logic                              eng_in_tlast,
  input  logic [NUM_ENGINES-1:0]            eng_in_tready,
  input  logic [NUM_ENGINES-1:0]            eng_out_tvalid,
  input  logic [NUM_ENGINES*DATA_WIDTH-1:0] eng_out_tdata,
  output logic [NUM_ENGINES-1:0]            eng_out_tready,
  output logic                              wmst_tvalid,
  output logic [DATA_WIDTH-1:0]             wmst_tdata,
  input  logic                              wmst_tready,
  output logic [NUM_ENGINES-1:0]            op_start,
  output logic [31:0]                       perf_cycles,
  output logic [31:0]                       perf_stalls
);

  localparam int unsigned ENG_W = idx_width(NUM_ENGINES);

  ctrl_state_e           state, next_state;
  logic                  start_acc, run;
  logic                  rd_flag, wr_flag, ready_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q, size_q;
  logic [ENG_W-1:0]      in_eng, out_eng;
  logic                  in_active, in_last, out_active, out_last_unused;
  logic [DATA_WIDTH-1:0] eng_out_arr [NUM_ENGINES];

  assign start_acc = (state == ST_IDLE) && ap_start;
  assign run       = (state == ST_RUN);

  rr_block_pointer #(.NUM_ENGINES(NUM_ENGINES), .BLOCK_WORDS(BLOCK_WORDS)) u_in_ptr (
    .clk      (aclk),
    .rst      (areset),
    .load     (start_acc),
    .words    (words_num),
    .enable   (run),
    .step     (rmst_tvalid && rmst_tready),
    .eng      (in_eng),
    .active_c (in_active),
    .last_c   (in_last)
  );

  rr_block_pointer #(.NUM_ENGINES(NUM_ENGINES), .BLOCK_WORDS(BLOCK_WORDS)) u_out_ptr (
    .clk      (aclk),
    .rst      (areset),
    .load     (start_acc),
    .words    (words_num),
    .enable   (run),
    .step     (wmst_tvalid && wmst_tready),
    .eng      (out_eng),
    .active_c (out_active),
    .last_c   (out_last_unused)
  );

  for (genvar k = 0; k < NUM_ENGINES; k++) begin : g_out_slice
    assign eng_out_arr[k] = eng_out_tdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Zero-latency stream steering; valid never looks at ready.
  always_comb begin
    eng_in_tvalid          = '0;
    eng_in_tvalid[in_eng]  = in_active && rmst_tvalid;
    rmst_tready            = in_active && eng_in_tready[in_eng];
    eng_in_tdata           = rmst_tdata;
    eng_in_tlast           = in_active && in_last;
    wmst_tvalid            = out_active && eng_out_tvalid[out_eng];
    wmst_tdata             = eng_out_arr[out_eng];
    eng_out_tready         = '0;
    eng_out_tready[out_eng] = out_active && wmst_tready;
  end

  always_ff @(posedge aclk) begin
    if (areset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (ap_start) next_state = (words_num == 32'd0) ? ST_DONE : ST_REQ;
      ST_REQ:       next_state = ST_RUN;
      ST_RUN:       if (!in_active && !out_active) next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: if (rd_flag && wr_flag) next_state = ST_DONE;
      ST_DONE:      if (ap_continue) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ap_idle    = (state == ST_IDLE);
    ap_done    = (state == ST_DONE);
    ap_ready   = ready_q;
    rmst_start = (state == ST_REQ);
    wmst_start = (state == ST_REQ);
    op_start   = {NUM_ENGINES{state == ST_REQ}};
  end

  // Job parameters held from start acceptance until the next job.
  always_ff @(posedge aclk) begin
    if (areset) begin
      src_q  <= '0;
      dst_q  <= '0;
      size_q <= '0;
    end else if (start_acc) begin
      src_q  <= src_addr;
      dst_q  <= dest_addr;
      size_q <= ADDR_WIDTH'(words_num) * ADDR_WIDTH'(WORD_BYTES(DATA_WIDTH));
    end
  end

  assign rmst_addr = src_q;
  assign wmst_addr = dst_q;
  assign rmst_size = size_q;
  assign wmst_size = size_q;

  // Master completions may land any time after the request, in any order.
  always_ff @(posedge aclk) begin
    if (areset || start_acc) begin
      rd_flag <= 1'b0;
      wr_flag <= 1'b0;
    end else if (state == ST_REQ || state == ST_RUN || state == ST_WAIT_DONE) begin
      rd_flag <= rd_flag || rmst_done;
      wr_flag <= wr_flag || wmst_done;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) ready_q <= 1'b0;
    else        ready_q <= (next_state == ST_DONE) && (state != ST_DONE);
  end

`ifdef MULTI_ENGINE_CONTROL_PERF_EN
  logic [31:0] cyc_q, stall_q;

  always_ff @(posedge aclk) begin
    if (areset || start_acc) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      if ((state == ST_REQ || run || state == ST_WAIT_DONE) && cyc_q != '1)
        cyc_q <= cyc_q + 32'd1;
      if (run && rmst_tvalid && !rmst_tready && stall_q != '1)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_stalls = stall_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_multi_engine_control.sv
// Directed bench for multi_engine_control: 4 engines, 2-beat blocks,
// behavioural source, echo engines (+0x1000) and sink.
module tb_multi_engine_control;

  localparam int unsigned DW = 512;
  localparam int unsigned NE = 4;
  localparam int unsigned BW = 2;
  localparam int unsigned AW = 64;

  logic              aclk;
  logic              areset, ap_start, ap_continue;
  logic              ap_idle, ap_ready, ap_done;
  logic [AW-1:0]     src_addr, dest_addr;
  logic [31:0]       words_num;
  logic              rmst_start, rmst_done, wmst_start, wmst_done;
  logic [AW-1:0]     rmst_addr, rmst_size, wmst_addr, wmst_size;
  logic              rmst_tvalid, rmst_tready;
  logic [DW-1:0]     rmst_tdata;
  logic [NE-1:0]     eng_in_tvalid, eng_in_tready;
  logic [DW-1:0]     eng_in_tdata;
  logic              eng_in_tlast;
  logic [NE-1:0]     eng_out_tvalid, eng_out_tready;
  logic [NE*DW-1:0]  eng_out_tdata;
  logic              wmst_tvalid, wmst_tready;
  logic [DW-1:0]     wmst_tdata;
  logic [NE-1:0]     op_start;
  logic [31:0]       perf_cycles, perf_stalls;

  multi_engine_control #(
    .DATA_WIDTH(DW), .NUM_ENGINES(NE), .BLOCK_WORDS(BW), .ADDR_WIDTH(AW)
  ) dut (
    .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
    .src_addr(src_addr), .dest_addr(dest_addr), .words_num(words_num),
    .rmst_start(rmst_start), .rmst_addr(rmst_addr), .rmst_size(rmst_size), .rmst_done(rmst_done),
    .wmst_start(wmst_start), .wmst_addr(wmst_addr), .wmst_size(wmst_size), .wmst_done(wmst_done),
    .rmst_tvalid(rmst_tvalid), .rmst_tdata(rmst_tdata), .rmst_tready(rmst_tready),
    .eng_in_tvalid(eng_in_tvalid), .eng_in_tdata(eng_in_tdata), .eng_in_tlast(eng_in_tlast),
    .eng_in_tready(eng_in_tready),
    .eng_out_tvalid(eng_out_tvalid), .eng_out_tdata(eng_out_tdata), .eng_out_tready(eng_out_tready),
    .wmst_tvalid(wmst_tvalid), .wmst_tdata(wmst_tdata), .wmst_tready(wmst_tready),
    .op_start(op_start), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          n_cmp, n_err;
  int          src_n, src_i, in_n, out_n;
  int          rs_cnt, ws_cnt, ready_cnt, op_cnt;
  logic [31:0] emem [NE][32];
  int          ewp [NE];
  int          erp [NE];
  logic [NE-1:0] erdy;
  int          in_eng_log [64];
  logic        in_last_log [64];
  logic [31:0] in_dat_log [64];
  logic [31:0] out_log [64];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    src_n = 0; src_i = 0; in_n = 0; out_n = 0;
    rs_cnt = 0; ws_cnt = 0; ready_cnt = 0; op_cnt = 0;
    erdy = '1;
    for (int k = 0; k < NE; k++) begin
      ewp[k] = 0;
      erp[k] = 0;
    end
  endtask

  task automatic drive();
    rmst_tvalid   = (src_i < src_n);
    rmst_tdata    = DW'(32'h100 + 32'(src_i));
    eng_in_tready = erdy;
    wmst_tready   = 1'b1;
    for (int k = 0; k < NE; k++) begin
      eng_out_tvalid[k] = (erp[k] < ewp[k]);
      eng_out_tdata[k*DW +: DW] = eng_out_tvalid[k] ? DW'(emem[k][erp[k]] + 32'h1000) : '0;
    end
  endtask

  // Observe the handshakes that the coming rising edge will complete.
  task automatic sample();
    int k;
    if (!areset) begin
      if (rmst_start) rs_cnt++;
      if (wmst_start) ws_cnt++;
      if (ap_ready) ready_cnt++;
      if (op_start != '0) op_cnt++;
      if (rmst_tvalid && rmst_tready) begin
        k = -1;
        for (int j = 0; j < NE; j++) if (eng_in_tvalid[j]) k = j;
        if (in_n < 64) begin
          in_eng_log[in_n]  = k;
          in_last_log[in_n] = eng_in_tlast;
          in_dat_log[in_n]  = eng_in_tdata[31:0];
        end
        in_n++;
        if (k >= 0 && ewp[k] < 32) begin
          emem[k][ewp[k]] = eng_in_tdata[31:0];
          ewp[k]++;
        end
        src_i++;
      end
      if (wmst_tvalid && wmst_tready) begin
        k = -1;
        for (int j = 0; j < NE; j++) if (eng_out_tready[j]) k = j;
        if (out_n < 64) out_log[out_n] = wmst_tdata[31:0];
        out_n++;
        if (k >= 0) erp[k]++;
      end
    end
  endtask

  task automatic tick();
    drive();
    #4;
    sample();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic start_job(input int words, input logic [AW-1:0] src, input logic [AW-1:0] dst);
    model_clear();
    src_n     = words;
    words_num = 32'(words);
    src_addr  = src;
    dest_addr = dst;
    ap_start  = 1'b1;
    tick();
    ap_start  = 1'b0;
  endtask

  // Read done rides on the last input beat; write done follows the last output beat.
  task automatic run_job(input int stall_len);
    int held;
    bit rd_sent, wr_sent, chk;
    held = 0; rd_sent = 0; wr_sent = 0; chk = 0;
    for (int c = 0; c < 200 && !ap_done; c++) begin
      if (stall_len > 0 && held == stall_len && !chk) begin
        check_eq("stall_hold_src_idx", 64'(src_i), 64'd2);
        chk = 1;
      end
      erdy = '1;
      if (stall_len > 0 && src_i == 2 && held < stall_len) begin
        erdy[1] = 1'b0;
        held++;
      end
      rmst_done = !rd_sent && (src_i == src_n - 1);
      wmst_done = !wr_sent && (out_n == src_n);
      rd_sent   = rd_sent || rmst_done;
      wr_sent   = wr_sent || wmst_done;
      tick();
    end
    rmst_done = 1'b0;
    wmst_done = 1'b0;
    check_eq("job_done", 64'(ap_done), 64'd1);
  endtask

  task automatic finish_job();
    tick();
    tick();
    check_eq("ap_ready_single_pulse", 64'(ready_cnt), 64'd1);
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    check_eq("idle_after_continue", 64'(ap_idle), 64'd1);
  endtask

  task automatic check_data(input int n);
    check_eq("in_beats", 64'(in_n), 64'(n));
    check_eq("out_beats", 64'(out_n), 64'(n));
    for (int i = 0; i < n && i < 64; i++) begin
      check_eq($sformatf("beat%0d_eng", i), 64'(in_eng_log[i]), 64'((i / BW) % NE));
      check_eq($sformatf("beat%0d_tlast", i), 64'(in_last_log[i]),
               64'((i % BW == BW - 1) || (i == n - 1)));
      check_eq($sformatf("beat%0d_in_data", i), 64'(in_dat_log[i]), 64'(32'h100 + i));
      check_eq($sformatf("beat%0d_out_data", i), 64'(out_log[i]), 64'(32'h1100 + i));
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    areset = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    src_addr = '0; dest_addr = '0; words_num = '0;
    rmst_done = 1'b0; wmst_done = 1'b0;
    eng_out_tvalid = '0; eng_out_tdata = '0;
    model_clear();
    drive();
    @(negedge aclk);

    // Reset state
    tick(); tick(); tick();
    check_eq("rst_ap_idle", 64'(ap_idle), 64'd1);
    check_eq("rst_ap_done", 64'(ap_done), 64'd0);
    check_eq("rst_ap_ready", 64'(ap_ready), 64'd0);
    check_eq("rst_rmst_start", 64'(rmst_start), 64'd0);
    check_eq("rst_rmst_size", rmst_size, 64'd0);
    check_eq("rst_eng_in_tvalid", 64'(eng_in_tvalid), 64'd0);
    check_eq("rst_wmst_tvalid", 64'(wmst_tvalid), 64'd0);
    check_eq("rst_op_start", 64'(op_start), 64'd0);
    areset = 1'b0;
    tick();

    // Eight beats, four full blocks
    start_job(8, 64'h1000, 64'h2000);
    check_eq("req_rmst_start", 64'(rmst_start), 64'd1);
    check_eq("req_wmst_start", 64'(wmst_start), 64'd1);
    check_eq("req_op_start", 64'(op_start), 64'hF);
    check_eq("req_rmst_addr", rmst_addr, 64'h1000);
    check_eq("req_wmst_addr", wmst_addr, 64'h2000);
    check_eq("req_rmst_size", rmst_size, 64'd512);
    check_eq("req_wmst_size", wmst_size, 64'd512);
    check_eq("req_ap_idle", 64'(ap_idle), 64'd0);
    run_job(0);
    check_eq("j8_rmst_start_count", 64'(rs_cnt), 64'd1);
    check_eq("j8_wmst_start_count", 64'(ws_cnt), 64'd1);
    check_eq("j8_op_start_count", 64'(op_cnt), 64'd1);
    check_eq("j8_addr_stable", rmst_addr, 64'h1000);
    check_data(8);
    finish_job();

    // Five beats, short final block on engine 2
    start_job(5, 64'h3000, 64'h4000);
    check_eq("j5_size", rmst_size, 64'd320);
    run_job(0);
    check_data(5);
    finish_job();

    // Zero-length job
    start_job(0, 64'h5000, 64'h6000);
    tick();
    check_eq("j0_ap_done", 64'(ap_done), 64'd1);
    check_eq("j0_ap_idle", 64'(ap_idle), 64'd0);
    finish_job();
    check_eq("j0_no_rmst_start", 64'(rs_cnt), 64'd0);
    check_eq("j0_no_wmst_start", 64'(ws_cnt), 64'd0);

    // Engine 1 backpressure for ten cycles
    start_job(8, 64'h7000, 64'h8000);
    run_job(10);
    check_data(8);
`ifdef MULTI_ENGINE_CONTROL_PERF_EN
    check_eq("perf_stalls", 64'(perf_stalls), 64'd10);
    check_eq("perf_cycles_nonzero", 64'(perf_cycles != 32'd0), 64'd1);
`else
    check_eq("perf_stalls_tied", 64'(perf_stalls), 64'd0);
    check_eq("perf_cycles_tied", 64'(perf_cycles), 64'd0);
`endif
    finish_job();

    // Write done three cycles ahead of read done
    start_job(4, 64'h9000, 64'hA000);
    for (int c = 0; c < 50 && out_n < 4; c++) tick();
    check_eq("jo_out_beats", 64'(out_n), 64'd4);
    wmst_done = 1'b1;
    tick();
    wmst_done = 1'b0;
    check_eq("jo_no_done_c0", 64'(ap_done), 64'd0);
    tick();
    check_eq("jo_no_done_c1", 64'(ap_done), 64'd0);
    tick();
    check_eq("jo_no_done_c2", 64'(ap_done), 64'd0);
    rmst_done = 1'b1;
    tick();
    rmst_done = 1'b0;
    for (int c = 0; c < 5 && !ap_done; c++) tick();
    check_eq("jo_done_after_both", 64'(ap_done), 64'd1);
    check_data(4);
    finish_job();

    // Reset in the middle of RUN, then a clean job
    start_job(8, 64'hB000, 64'hC000);
    tick(); tick(); tick();
    areset = 1'b1;
    tick();
    check_eq("mid_rst_ap_idle", 64'(ap_idle), 64'd1);
    check_eq("mid_rst_eng_in_tvalid", 64'(eng_in_tvalid), 64'd0);
    check_eq("mid_rst_wmst_tvalid", 64'(wmst_tvalid), 64'd0);
    check_eq("mid_rst_rmst_tready", 64'(rmst_tready), 64'd0);
    check_eq("mid_rst_eng_out_tready", 64'(eng_out_tready), 64'd0);
    areset = 1'b0;
    tick();
    start_job(6, 64'hD000, 64'hE000);
    check_eq("post_rst_rmst_addr", rmst_addr, 64'hD000);
    run_job(0);
    check_eq("post_rst_rmst_start_count", 64'(rs_cnt), 64'd1);
    check_data(6);
    finish_job();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_engine_control.md
# multi_engine_control

Parametrised successor to the single-engine kernel control path: accepts one kernel invocation (ap_ctrl handshake), issues one read-master and one write-master request, and distributes input beats to `NUM_ENGINES` compute engines in round-robin blocks of `BLOCK_WORDS`. Engine results are collected in the same block order, so output ordering equals input ordering. Sits between `axi_read_master`/`axi_write_master` and the engine array inside the kernel top.

## Interface
- `DATA_WIDTH`, 512: stream beat width in bits; one beat is one word of `DATA_WIDTH/8` bytes.
- `NUM_ENGINES`, 4: engine count, 1..16.
- `BLOCK_WORDS`, 16: beats per engine block; power of two, 1..256.
- `ADDR_WIDTH`, 64: address and transfer-size width.

Ports:
- `aclk` in 1: clock. Single clock domain.
- `areset` in 1: reset, synchronous, active-high.
- `ap_start` in 1, `ap_continue` in 1; `ap_idle` out 1, `ap_ready` out 1, `ap_done` out 1: kernel control.
- `src_addr`, `dest_addr` in `ADDR_WIDTH`; `words_num` in 32: job parameters, sampled on start.
- `rmst_start` out 1, `rmst_addr` out `ADDR_WIDTH`, `rmst_size` out `ADDR_WIDTH`, `rmst_done` in 1: read-master request.
- `wmst_start` out 1, `wmst_addr` out `ADDR_WIDTH`, `wmst_size` out `ADDR_WIDTH`, `wmst_done` in 1: write-master request.
- `rmst_tvalid` in 1, `rmst_tdata` in `DATA_WIDTH`, `rmst_tready` out 1: input stream.
- `eng_in_tvalid` out `NUM_ENGINES` (one-hot), `eng_in_tdata` out `DATA_WIDTH` (broadcast), `eng_in_tlast` out 1, `eng_in_tready` in `NUM_ENGINES`: engine input.
- `eng_out_tvalid` in `NUM_ENGINES`, `eng_out_tdata` in `NUM_ENGINES*DATA_WIDTH` (engine k at bits `[k*DATA_WIDTH +: DATA_WIDTH]`), `eng_out_tready` out `NUM_ENGINES` (one-hot): engine results.
- `wmst_tvalid` out 1, `wmst_tdata` out `DATA_WIDTH`, `wmst_tready` in 1: output stream.
- `op_start` out `NUM_ENGINES`: one-cycle start pulse to all engines.
- `perf_cycles`, `perf_stalls` out 32: performance counters.

## Operation
- FSM states: IDLE → REQ → RUN → WAIT_DONE → DONE → IDLE.
- IDLE: `ap_idle`=1. When `ap_start`=1, latch the job parameters and go to REQ. If `words_num`=0, go straight to DONE with no requests issued.
- REQ, one cycle: pulse `rmst_start`, `wmst_start`, and all `op_start` bits.
  - `rmst_addr`=`src_addr`, `wmst_addr`=`dest_addr`.
  - Both sizes = `words_num*(DATA_WIDTH/8)`, zero-extended to `ADDR_WIDTH`.
  - Addresses and sizes stay stable until IDLE.
- RUN, input side: `in_eng` engine index, `in_cnt` beat-in-block counter, `in_rem` remaining beats.
  - `eng_in_tvalid[in_eng]`=`rmst_tvalid` while `in_rem`≠0.
  - `rmst_tready`=`eng_in_tready[in_eng]`, gated the same way.
  - On handshake: decrement `in_rem` and increment `in_cnt`. When `in_cnt` reaches `BLOCK_WORDS-1`, or `in_rem`=1, reset `in_cnt` and advance `in_eng`, wrapping at `NUM_ENGINES-1`.
  - `eng_in_tlast`=1 on the final beat of each block, including a short final block.
- RUN, output side: identical counters `out_eng`/`out_cnt`/`out_rem`, muxing `eng_out_*[out_eng]` onto `wmst_*`.
- Leave RUN for WAIT_DONE when `in_rem`=0 and `out_rem`=0.
- WAIT_DONE: latch `rmst_done` and `wmst_done` as sticky flags; they may arrive in any order, and either may arrive earlier in RUN. Go to DONE when both are set.
- DONE: hold `ap_done`=1; pulse `ap_ready` for one cycle on entry. Go to IDLE on `ap_continue`=1. `ap_start` is ignored outside IDLE.

## Timing
- Stream paths are combinational, with zero-cycle latency: in→engine and engine→out.
- Handshakes follow AXI-Stream rules: transfer on valid&ready; valid never depends on ready.
- The request pulse occurs exactly one cycle after `ap_start` is sampled.
- Reset values:
  - All outputs 0 except `ap_idle`=1.
  - Counters and sticky flags cleared; FSM in IDLE.
- Reset mid-job aborts immediately. No request is re-issued, and the engines are not notified beyond the dropped valids.
- A `done` arriving in the same cycle as the last beat is captured.

## Configuration
- `MULTI_ENGINE_CONTROL_PERF_EN` defined:
  - `perf_cycles` counts cycles from REQ to DONE entry.
  - `perf_stalls` counts RUN cycles with `rmst_tvalid`=1 and `rmst_tready`=0.
  - Both saturate at 2^32−1 and clear on start acceptance.
- Not defined: both ports are tied to 0, and no counter logic is built.

## Structure
- Package `engine_ctrl_pkg`: FSM state enum, and a `WORD_BYTES` function of `DATA_WIDTH`.
- One sub-module, `rr_block_pointer`: `in_eng`/`in_cnt`/`in_rem` with advance/last logic. Instantiated twice, for the input and output sides.

## Test plan
- `NUM_ENGINES`=4, `BLOCK_WORDS`=2, `words_num`=8, no backpressure:
  - Engines receive beats 0-1, 2-3, 4-5, 6-7 respectively, with tlast on beats 1, 3, 5, 7.
  - `wmst` order is 0..7; sizes=512.
- `words_num`=5, `BLOCK_WORDS`=2: engine 2 gets a single-beat block with tlast=1. Output completes after 5 beats.
- `words_num`=0: no `rmst_start`/`wmst_start`; `ap_done`=1 two cycles after start.
- Engine 1 holds tready=0 for 10 cycles: input stalls and no beat is lost. With the macro, `perf_stalls`=10.
- `wmst_done` arrives 3 cycles before `rmst_done`: `ap_done` asserts only after both; `ap_ready` is a single pulse.
- `areset` asserted mid-RUN: next cycle `ap_idle`=1 and all valids=0. A new `ap_start` runs a full job correctly.
